// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : uart_pkg                                                     |
// | Description : Shared state encoding and frame timing for uart_tx_arbiter.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam int CLKS_PER_BIT = 433;
  // One 11-bit frame plus four clocks of guard time between frames.
  localparam int FRAME_CLKS_DEF = 11 * CLKS_PER_BIT + 4;

  localparam logic [7:0] TAG_BASE = 8'h30;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TAG_ISSUE = 3'd1,
    ST_TAG_WAIT  = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT      = 3'd4
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                   |
// | Description : Combinational round-robin search starting after last_grant. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic             any,
  output logic [IDX_W-1:0] winner
);

  logic w_found;
  int   w_idx;

  always_comb begin
    any     = |req;
    winner  = last_grant;
    w_found = 1'b0;
    w_idx   = 0;
    // k runs 1..N_REQ so last_grant itself is considered last.
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = (int'(last_grant) + k) % N_REQ;
      if (!w_found && req[w_idx]) begin
        winner  = IDX_W'(w_idx);
        w_found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_arbiter                                              |
// | Description : Round-robin byte arbiter feeding one UART transmitter with   |
// |               FRAME_CLKS spacing. Define UART_ARB_TAG_EN to prefix every   |
// |               grant with an ASCII requester-index tag frame.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int FRAME_CLKS = FRAME_CLKS_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*8-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(FRAME_CLKS - 1);

  arb_state_t       r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [IDX_W-1:0] r_last, w_last_nx;
  logic [7:0]       r_byte, w_byte_nx;
  logic [N_REQ-1:0] w_ready_nx;
  logic             w_txv_nx;
  logic [7:0]       w_txd_nx;
  logic             w_busy_nx;
  logic [IDX_W-1:0] w_grant_nx;
  logic             w_any;
  logic [IDX_W-1:0] w_winner;
`ifdef UART_ARB_TAG_EN
  logic             r_gap, w_gap_nx;
`endif

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (r_last),
    .any        (w_any),
    .winner     (w_winner)
  );

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_last_nx  = r_last;
    w_byte_nx  = r_byte;
    w_ready_nx = '0;
    w_txv_nx   = 1'b0;
    w_txd_nx   = tx_data;
    w_grant_nx = grant_id;
`ifdef UART_ARB_TAG_EN
    w_gap_nx   = r_gap;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_byte_nx            = req_data[{w_winner, 3'b000} +: 8];
          w_grant_nx           = w_winner;
          w_last_nx            = w_winner;
          w_ready_nx[w_winner] = 1'b1;
`ifdef UART_ARB_TAG_EN
          w_state_nx           = ST_TAG_ISSUE;
`else
          w_state_nx           = ST_ISSUE;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      ST_TAG_ISSUE: begin
        w_txv_nx   = 1'b1;
        w_txd_nx   = TAG_BASE + 8'(grant_id);
        w_cnt_nx   = c_cnt_load;
        w_gap_nx   = 1'b0;
        w_state_nx = ST_TAG_WAIT;
      end
      ST_TAG_WAIT: begin
        // The extra gap cycle stands in for the IDLE cycle between plain
        // frames, keeping tag-to-data spacing equal to grant-to-grant spacing.
        if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end else if (!r_gap) begin
          w_gap_nx = 1'b1;
        end else begin
          w_gap_nx   = 1'b0;
          w_state_nx = ST_ISSUE;
        end
      end
`endif
      ST_ISSUE: begin
        w_txv_nx   = 1'b1;
        w_txd_nx   = r_byte;
        w_cnt_nx   = c_cnt_load;
        w_state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nx = ST_IDLE;
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
    w_busy_nx = (w_state_nx != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_last    <= IDX_W'(N_REQ - 1);
      r_byte    <= 8'h00;
      req_ready <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      busy      <= 1'b0;
      grant_id  <= '0;
`ifdef UART_ARB_TAG_EN
      r_gap     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_last    <= w_last_nx;
      r_byte    <= w_byte_nx;
      req_ready <= w_ready_nx;
      tx_valid  <= w_txv_nx;
      tx_data   <= w_txd_nx;
      busy      <= w_busy_nx;
      grant_id  <= w_grant_nx;
`ifdef UART_ARB_TAG_EN
      r_gap     <= w_gap_nx;
`endif
    end
  end

endmodule

`default_nettype wire
